// File: rtl/game_move_controller.sv
// game_move_controller: move-entry controller for a BOARD_DIM x BOARD_DIM board game.
// Samples a one-hot switch selection on a button press, validates it against the
// board register, requests a symbol draw, waits for the drawer, checks for a win
// and alternates players.
// Optional feature macro: GAME_TIE_DETECT_EN (full board with no win ends the game as a tie).
module game_move_controller #(
    parameter int BOARD_DIM = 3,
    parameter int SW_W = 10,
    localparam int N_CELLS = BOARD_DIM * BOARD_DIM,
    localparam int IDX_W = $clog2(N_CELLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SW_W-1:0]      SW,
    input  logic                 button,
    input  logic                 draw_done,
    output logic                 draw_start,
    output logic [IDX_W-1:0]     draw_cell,
    output logic                 draw_player,
    output logic [2*N_CELLS-1:0] board,
    output logic                 player,
    output logic                 holding,
    output logic                 move_invalid,
    output logic                 gameover,
    output logic [1:0]           winner
);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, EVAL, OVER} state_t;

    state_t               state;
    state_t               state_next;
    logic                 btn_q;
    logic                 press;
    logic [N_CELLS-1:0]   sel_q;
    logic [2*N_CELLS-1:0] board_q;
    logic                 player_q;
    logic [1:0]           winner_q;
    logic [IDX_W-1:0]     draw_cell_q;
    logic                 draw_player_q;
    logic                 sel_onehot;
    logic [IDX_W-1:0]     sel_idx;
    logic [1:0]           sel_cell;
    logic                 move_valid;
    logic [1:0]           win_code;
    logic [1:0]           line_code;
    logic                 line_all;
    logic                 tie_now;
    logic                 unused_sw;

    assign press      = button & ~btn_q;
    assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
    assign move_valid = sel_onehot && (sel_cell == 2'b00);
    assign unused_sw  = ^SW;

    // Decode the latched selection into a cell index and that cell's current contents
    always_comb begin
        sel_idx  = '0;
        sel_cell = 2'b00;
        for (int i = 0; i < N_CELLS; i++) begin
            if (sel_q[i]) begin
                sel_idx  = IDX_W'(i);
                sel_cell = board_q[2*i +: 2];
            end
        end
    end

    // Scan every row, column and both diagonals for a line of one non-empty symbol
    always_comb begin
        win_code  = 2'b00;
        line_code = 2'b00;
        line_all  = 1'b0;
        for (int r = 0; r < BOARD_DIM; r++) begin
            line_code = board_q[2*(r*BOARD_DIM) +: 2];
            line_all  = (line_code != 2'b00);
            for (int c = 0; c < BOARD_DIM; c++) begin
                if (board_q[2*(r*BOARD_DIM + c) +: 2] != line_code) line_all = 1'b0;
            end
            if (line_all) win_code = line_code;
        end
        for (int c = 0; c < BOARD_DIM; c++) begin
            line_code = board_q[2*c +: 2];
            line_all  = (line_code != 2'b00);
            for (int r = 0; r < BOARD_DIM; r++) begin
                if (board_q[2*(r*BOARD_DIM + c) +: 2] != line_code) line_all = 1'b0;
            end
            if (line_all) win_code = line_code;
        end
        line_code = board_q[1:0];
        line_all  = (line_code != 2'b00);
        for (int k = 0; k < BOARD_DIM; k++) begin
            if (board_q[2*(k*BOARD_DIM + k) +: 2] != line_code) line_all = 1'b0;
        end
        if (line_all) win_code = line_code;
        line_code = board_q[2*(BOARD_DIM-1) +: 2];
        line_all  = (line_code != 2'b00);
        for (int k = 0; k < BOARD_DIM; k++) begin
            if (board_q[2*(k*BOARD_DIM + BOARD_DIM - 1 - k) +: 2] != line_code) line_all = 1'b0;
        end
        if (line_all) win_code = line_code;
    end

`ifdef GAME_TIE_DETECT_EN
    // A board with no empty cell left ends the game when nobody has won
    always_comb begin
        tie_now = 1'b1;
        for (int i = 0; i < N_CELLS; i++) begin
            if (board_q[2*i +: 2] == 2'b00) tie_now = 1'b0;
        end
    end
`else
    assign tie_now = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and the single-cycle strobes
    always_comb begin
        state_next   = state;
        draw_start   = 1'b0;
        move_invalid = 1'b0;
        case (state)
            IDLE:  if (press) state_next = CHECK;
            CHECK: begin
                if (move_valid) begin
                    state_next = ISSUE;
                end else begin
                    move_invalid = 1'b1;
                    state_next   = IDLE;
                end
            end
            ISSUE: begin
                draw_start = 1'b1;
                state_next = WAIT;
            end
            WAIT:  if (draw_done) state_next = EVAL;
            EVAL: begin
                if (win_code != 2'b00 || tie_now) state_next = OVER;
                else                             state_next = IDLE;
            end
            OVER:    state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    // Button history, selection latch, board, player, winner and draw descriptor
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q         <= 1'b0;
            sel_q         <= '0;
            board_q       <= '0;
            player_q      <= 1'b0;
            winner_q      <= 2'b00;
            draw_cell_q   <= '0;
            draw_player_q <= 1'b0;
        end else begin
            btn_q <= button;
            case (state)
                IDLE: if (press) sel_q <= SW[N_CELLS-1:0];
                CHECK: begin
                    if (move_valid) begin
                        for (int i = 0; i < N_CELLS; i++) begin
                            if (sel_q[i]) board_q[2*i +: 2] <= {player_q, ~player_q};
                        end
                        draw_cell_q   <= sel_idx;
                        draw_player_q <= player_q;
                    end
                end
                EVAL: begin
                    if (win_code != 2'b00) winner_q <= win_code;
                    else if (tie_now)      winner_q <= 2'b11;
                    else                   player_q <= ~player_q;
                end
                default: ;
            endcase
        end
    end

    assign board       = board_q;
    assign player      = player_q;
    assign winner      = winner_q;
    assign draw_cell   = draw_cell_q;
    assign draw_player = draw_player_q;
    assign holding     = (state != IDLE);
    assign gameover    = (state == OVER);

endmodule
